ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the decode→ALU pipeline register. It consumes the registered operands, ALU opcode and write-back tag and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations. While it computes, it asserts a stall toward the front end. It returns the result with its write-back tag to the ALU→MEM register for one cycle.

---
 rtl/ex_muldiv_pkg.sv | 44 ++++
 rtl/ex_muldiv_if.sv | 30 +++
 rtl/ex_muldiv_md_signfix.sv | 64 ++++++
 rtl/ex_muldiv.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared widths, RV32M opcode constants, FSM state type and
// operand classification helpers for the iterative multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_CTRL_W = 5;
    localparam int unsigned MD_ITERS   = 32;

    localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 5'h18;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = 5'h19;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = 5'h1A;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = 5'h1B;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIV    = 5'h1C;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIVU   = 5'h1D;
    localparam logic [ALU_CTRL_W-1:0] ALU_REM    = 5'h1E;
    localparam logic [ALU_CTRL_W-1:0] ALU_REMU   = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input logic [ALU_CTRL_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic md_is_rem(input logic [ALU_CTRL_W-1:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // Divides whose result is fixed by the ISA rather than by iteration:
    // divide by zero, and the signed most-negative / -1 overflow.
    function automatic logic md_special(input logic [ALU_CTRL_W-1:0] op,
                                        input logic [DATA_W-1:0]     a,
                                        input logic [DATA_W-1:0]     b);
        logic signed_div;
        signed_div = (op == ALU_DIV) || (op == ALU_REM);
        return md_is_div(op) &&
               ((b == '0) || (signed_div && (a == 32'h8000_0000) && (b == '1)));
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: execute-stage bundle between the pipeline and ex_muldiv.
//   master: pipeline side (drives start/op/operands/tag/flush, sees busy/result)
//   slave : multiply/divide unit
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic                  start;
    logic [ALU_CTRL_W-1:0] op;
    logic [DATA_W-1:0]     dataAlu1;
    logic [DATA_W-1:0]     dataAlu2;
    logic [REG_ADDR_W-1:0] writeBackAddrIn;
    logic                  writeEnableIn;
    logic                  flush;
    logic                  busy;
    logic                  resultValid;
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] writeBackAddrOut;
    logic                  writeEnableOut;

    modport master (
        output start, op, dataAlu1, dataAlu2, writeBackAddrIn, writeEnableIn, flush,
        input  busy, resultValid, result, writeBackAddrOut, writeEnableOut
    );

    modport slave (
        input  start, op, dataAlu1, dataAlu2, writeBackAddrIn, writeEnableIn, flush,
        output busy, resultValid, result, writeBackAddrOut, writeEnableOut
    );

endinterface

// File: rtl/ex_muldiv_md_signfix.sv
// md_signfix: combinational operand magnitude extraction and final result
// selection (sign fix-up, high/low product word, divide special cases).
//   op            latched opcode
//   rs1, rs2      latched raw operands
//   prod_mag      unsigned 64-b product of the magnitudes
//   quo_mag/rem_mag unsigned quotient/remainder of the magnitudes
//   rs1_mag/rs2_mag operand magnitudes fed to the iteration datapath
//   result        architectural result word
module md_signfix
    import ex_muldiv_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] op,
    input  logic [DATA_W-1:0]     rs1,
    input  logic [DATA_W-1:0]     rs2,
    input  logic [2*DATA_W-1:0]   prod_mag,
    input  logic [DATA_W-1:0]     quo_mag,
    input  logic [DATA_W-1:0]     rem_mag,
    output logic [DATA_W-1:0]     rs1_mag,
    output logic [DATA_W-1:0]     rs2_mag,
    output logic [DATA_W-1:0]     result
);

    logic                rs1_signed;
    logic                rs2_signed;
    logic                rs1_neg;
    logic                rs2_neg;
    logic                neg_res;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;

    always_comb begin
        rs1_signed = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
        rs2_signed = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
        rs1_neg    = rs1_signed & rs1[DATA_W-1];
        rs2_neg    = rs2_signed & rs2[DATA_W-1];
        rs1_mag    = rs1_neg ? (32'd0 - rs1) : rs1;
        rs2_mag    = rs2_neg ? (32'd0 - rs2) : rs2;
        neg_res    = rs1_neg ^ rs2_neg;

        prod = neg_res ? (64'd0 - prod_mag) : prod_mag;
        quo  = neg_res ? (32'd0 - quo_mag)  : quo_mag;
        rem  = rs1_neg ? (32'd0 - rem_mag)  : rem_mag;

        result = '0;
        case (op)
            ALU_MUL:                           result = prod[DATA_W-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:   result = prod[2*DATA_W-1:DATA_W];
            ALU_DIV, ALU_DIVU:                 result = quo;
            ALU_REM, ALU_REMU:                 result = rem;
            default:                           result = '0;
        endcase

        // Overrides also cover the early-out path, where the iteration
        // registers still hold their cleared start values.
        if (md_special(op, rs1, rs2)) begin
            if (rs2 == '0)
                result = md_is_rem(op) ? rs1 : '1;
            else
                result = md_is_rem(op) ? '0 : 32'h8000_0000;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit (execute stage).
// Shift-add multiply and restoring divide, one bit per cycle, 32 iterations;
// result and write-back tag are presented for one cycle in DONE.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         ex_muldiv_if.slave (start/op/operands/tag/flush in;
//               busy/resultValid/result/writeBackAddrOut/writeEnableOut out)
// Optional: EX_MULDIV_EARLY_OUT_EN sends divide-by-zero and signed-overflow
// divides straight from IDLE to DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    ex_muldiv_if.slave     bus
);

    md_state_e             state_q, state_d;
    logic [4:0]            count_q;
    logic [ALU_CTRL_W-1:0] op_q;
    logic [DATA_W-1:0]     rs1_q, rs2_q;
    logic [DATA_W-1:0]     rs1_mag, rs2_mag;
    logic [2*DATA_W-1:0]   prod_q;
    logic [DATA_W-1:0]     quo_q, rem_q;
    logic [DATA_W-1:0]     result_q, fixed;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic                  wb_en_q;
    logic                  accept, early, last_iter;
    logic                  busy, res_valid;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_shift;
    logic                  div_ge;

`ifdef EX_MULDIV_EARLY_OUT_EN
    assign early = md_special(bus.op, bus.dataAlu1, bus.dataAlu2);
`else
    assign early = 1'b0;
`endif

    assign accept    = (state_q == IDLE) && bus.start && !bus.flush;
    assign last_iter = (count_q == 5'(MD_ITERS - 1));

    md_signfix u_signfix (
        .op       (op_q),
        .rs1      (rs1_q),
        .rs2      (rs2_q),
        .prod_mag (prod_q),
        .quo_mag  (quo_q),
        .rem_mag  (rem_q),
        .rs1_mag  (rs1_mag),
        .rs2_mag  (rs2_mag),
        .result   (fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        res_valid = (state_q == DONE) && !bus.flush;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = early ? DONE : CALC;
                CALC:    if (last_iter) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Multiply: add into the upper half, then shift {carry, hi, lo} right so
    // the low product bits fall into the lower half as the multiplier is consumed.
    assign mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                       (rs2_mag[count_q] ? {1'b0, rs1_mag} : '0);
    // Divide: 33-b partial remainder, dividend bits taken MSB first.
    assign div_shift = {rem_q, rs1_mag[5'd31 - count_q]};
    assign div_ge    = (div_shift >= {1'b0, rs2_mag});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            wb_addr_q <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= bus.op;
                rs1_q     <= bus.dataAlu1;
                rs2_q     <= bus.dataAlu2;
                wb_addr_q <= bus.writeBackAddrIn;
                wb_en_q   <= bus.writeEnableIn;
                count_q   <= '0;
                prod_q    <= '0;
                quo_q     <= '0;
                rem_q     <= '0;
            end else if (state_q == CALC) begin
                count_q <= count_q + 5'd1;
                prod_q  <= {mul_sum, prod_q[DATA_W-1:1]};
                if (div_ge) begin
                    rem_q <= div_shift[DATA_W-1:0] - rs2_mag;
                    quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_q <= div_shift[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                end
            end
            if (res_valid)
                result_q <= fixed;
        end
    end

    assign bus.busy             = busy;
    assign bus.resultValid      = res_valid;
    assign bus.result           = (state_q == DONE) ? fixed : result_q;
    assign bus.writeBackAddrOut = wb_addr_q;
    assign bus.writeEnableOut   = wb_en_q & res_valid;

endmodule
